program_mem_arbiter: RTL and testbench



---
 rtl/program_mem_arbiter_pkg.sv | 17 +
 rtl/program_mem_arbiter_if.sv | 35 +++
 rtl/program_mem_arbiter_rr_select.sv | 35 +++
 rtl/program_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_program_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_mem_arbiter_pkg.sv
// Shared types and helpers for the program-memory arbiter.
package program_mem_arbiter_pkg;

  // Channel state encodings are placed in a range that the core and
  // fetcher state machines never use, so traces stay unambiguous.
  typedef enum logic [3:0] {
    ARB_IDLE     = 4'hA,
    ARB_WAITING  = 4'hB,
    ARB_RELAYING = 4'hC
  } arb_channel_state_t;

  // Width of a consumer index; a single consumer still needs one bit.
  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/program_mem_arbiter_if.sv
// Fetcher-side and memory-side read channels of the program-memory arbiter.
interface program_mem_arbiter_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
);

  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;

  logic [NUM_CHANNELS-1:0]                 mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0]                 mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;

  // The arbiter's view.
  modport slave (
    input  consumer_read_valid, consumer_read_address,
    input  mem_read_ready, mem_read_data,
    output consumer_read_ready, consumer_read_data,
    output mem_read_valid, mem_read_address
  );

  // The fetchers' and memory's view.
  modport master (
    output consumer_read_valid, consumer_read_address,
    output mem_read_ready, mem_read_data,
    input  consumer_read_ready, consumer_read_data,
    input  mem_read_valid, mem_read_address
  );

endinterface

// File: rtl/program_mem_arbiter_rr_select.sv
// Round-robin pick of one eligible fetcher, starting the search at rr_ptr.
module program_mem_arbiter_rr_select
  import program_mem_arbiter_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int PTR_BITS      = ptr_bits(NUM_CONSUMERS)
) (
  input  logic [NUM_CONSUMERS-1:0] valid,
  input  logic [NUM_CONSUMERS-1:0] busy,
  input  logic [NUM_CONSUMERS-1:0] claimed,
  input  logic [PTR_BITS-1:0]      rr_ptr,
  output logic                     found,
  output logic [PTR_BITS-1:0]      index
);

  logic [NUM_CONSUMERS-1:0] candidates;
  logic [PTR_BITS-1:0]      slot;

  assign candidates = valid & ~busy & ~claimed;

  // Walk the consumers cyclically from rr_ptr and keep the first eligible one.
  always_comb begin
    found = 1'b0;
    index = '0;
    slot  = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      slot = PTR_BITS'((int'(rr_ptr) + i) % NUM_CONSUMERS);
      if (!found && candidates[slot]) begin
        found = 1'b1;
        index = slot;
      end
    end
  end

endmodule

// File: rtl/program_mem_arbiter.sv
// Shares the program-memory read channels among the per-core fetchers.
module program_mem_arbiter
  import program_mem_arbiter_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input logic                  clk,
  input logic                  reset,
  program_mem_arbiter_if.slave bus
);

  localparam int PTR_BITS = ptr_bits(NUM_CONSUMERS);

  arb_channel_state_t state      [NUM_CHANNELS];
  arb_channel_state_t next_state [NUM_CHANNELS];
  logic [PTR_BITS-1:0] owner     [NUM_CHANNELS];
  logic [PTR_BITS-1:0] pick      [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  grant;
  logic [NUM_CONSUMERS-1:0] busy;
  logic [PTR_BITS-1:0]      rr_ptr;
  logic [PTR_BITS-1:0]      rr_next;

  logic [NUM_CHANNELS-1:0]                 mem_valid_q;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_addr_q;
  logic [NUM_CONSUMERS-1:0]                cons_ready_q;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] cons_data_q;

  // Each channel gets its own selector; a consumer picked by a lower channel
  // is masked out for every higher channel in the same cycle.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_channel
    logic [NUM_CONSUMERS-1:0] claimed_in;
    logic                     found;
    logic [PTR_BITS-1:0]      index;

    if (c == 0) begin : g_first
      assign claimed_in = '0;
    end else begin : g_next
      assign claimed_in = g_channel[c-1].g_pass.claimed_out;
    end

    program_mem_arbiter_rr_select #(
      .NUM_CONSUMERS(NUM_CONSUMERS),
      .PTR_BITS     (PTR_BITS)
    ) u_select (
      .valid  (bus.consumer_read_valid),
      .busy   (busy),
      .claimed(claimed_in),
      .rr_ptr (rr_ptr),
      .found  (found),
      .index  (index)
    );

    assign grant[c] = (state[c] == ARB_IDLE) && found;
    assign pick[c]  = index;

    if (c + 1 < NUM_CHANNELS) begin : g_pass
      logic [NUM_CONSUMERS-1:0] claimed_out;
      assign claimed_out = claimed_in |
                           (grant[c] ? (NUM_CONSUMERS'(1) << index) : '0);
    end
  end

  // Channel next-state: claim a fetcher, wait for memory, hold data until released.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      next_state[c] = state[c];
      case (state[c])
        ARB_IDLE:     if (grant[c]) next_state[c] = ARB_WAITING;
        ARB_WAITING:  if (bus.mem_read_ready[c]) next_state[c] = ARB_RELAYING;
        ARB_RELAYING: if (!bus.consumer_read_valid[owner[c]]) next_state[c] = ARB_IDLE;
        default:      next_state[c] = ARB_IDLE;
      endcase
    end
  end

  // The pointer moves just past the grant made by the highest channel this cycle.
  always_comb begin
    rr_next = rr_ptr;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant[c]) begin
        rr_next = PTR_BITS'((int'(pick[c]) + 1) % NUM_CONSUMERS);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (reset) state[c] <= ARB_IDLE;
      else       state[c] <= next_state[c];
    end
  end

  // Registered datapath: ownership, busy flags, memory requests and fetcher replies.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      busy         <= '0;
      mem_valid_q  <= '0;
      mem_addr_q   <= '0;
      cons_ready_q <= '0;
      cons_data_q  <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) owner[c] <= '0;
    end else begin
      rr_ptr <= rr_next;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (state[c])
          ARB_IDLE: begin
            if (grant[c]) begin
              busy[pick[c]]  <= 1'b1;
              owner[c]       <= pick[c];
              mem_valid_q[c] <= 1'b1;
              mem_addr_q[c]  <= bus.consumer_read_address[pick[c]];
            end
          end
          ARB_WAITING: begin
            if (bus.mem_read_ready[c]) begin
              mem_valid_q[c]            <= 1'b0;
              cons_data_q[owner[c]]     <= bus.mem_read_data[c];
              cons_ready_q[owner[c]]    <= 1'b1;
            end
          end
          ARB_RELAYING: begin
            if (!bus.consumer_read_valid[owner[c]]) begin
              cons_ready_q[owner[c]] <= 1'b0;
              busy[owner[c]]         <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_read_valid      = mem_valid_q;
  assign bus.mem_read_address    = mem_addr_q;
  assign bus.consumer_read_ready = cons_ready_q;
  assign bus.consumer_read_data  = cons_data_q;

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Scoreboard bench for program_mem_arbiter: one single-channel and one dual-channel instance.
module tb_program_mem_arbiter;

  localparam int NC = 4;
  localparam int AB = 8;
  localparam int DB = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  program_mem_arbiter_if #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1),
                           .ADDR_BITS(AB), .DATA_BITS(DB)) bus_a ();
  program_mem_arbiter_if #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(2),
                           .ADDR_BITS(AB), .DATA_BITS(DB)) bus_b ();

  program_mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1),
                        .ADDR_BITS(AB), .DATA_BITS(DB)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  program_mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(2),
                        .ADDR_BITS(AB), .DATA_BITS(DB)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  typedef struct {
    int          which;
    int          idx;
    logic [15:0] val;
  } exp_t;

  exp_t exp_grant[$];
  exp_t exp_resp[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] cons_addr [NC] = '{8'h10, 8'h21, 8'h1A, 8'h43};

  logic [1:0] prev_mv [2] = '{default: '0};
  logic [3:0] prev_cr [2] = '{default: '0};

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int which, input int cons, input logic v);
    if (which == 0) begin
      bus_a.consumer_read_valid[cons[1:0]]   = v;
      bus_a.consumer_read_address[cons[1:0]] = cons_addr[cons[1:0]];
    end else begin
      bus_b.consumer_read_valid[cons[1:0]]   = v;
      bus_b.consumer_read_address[cons[1:0]] = cons_addr[cons[1:0]];
    end
  endtask

  task automatic mem_drive(input int which, input int ch, input logic rdy,
                           input logic [15:0] data);
    if (which == 0) begin
      bus_a.mem_read_ready[0] = rdy;
      bus_a.mem_read_data[0]  = data;
    end else begin
      bus_b.mem_read_ready[ch[0]] = rdy;
      bus_b.mem_read_data[ch[0]]  = data;
    end
  endtask

  task automatic expect_grant(input int which, input int ch, input int cons);
    exp_t e;
    e.which = which;
    e.idx   = ch;
    e.val   = {8'h00, cons_addr[cons[1:0]]};
    exp_grant.push_back(e);
  endtask

  task automatic expect_resp(input int which, input int cons, input logic [15:0] data);
    exp_t e;
    e.which = which;
    e.idx   = cons;
    e.val   = data;
    exp_resp.push_back(e);
  endtask

  task automatic do_reset();
    bus_a.consumer_read_valid   = '0;
    bus_a.consumer_read_address = '0;
    bus_a.mem_read_ready        = '0;
    bus_a.mem_read_data         = '0;
    bus_b.consumer_read_valid   = '0;
    bus_b.consumer_read_address = '0;
    bus_b.mem_read_ready        = '0;
    bus_b.mem_read_data         = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Serve one outstanding read: pulse the memory strobe and expect the reply next cycle.
  task automatic serve(input int which, input int ch, input int cons, input logic [15:0] data);
    expect_resp(which, cons, data);
    mem_drive(which, ch, 1'b1, data);
    tick();
    mem_drive(which, ch, 1'b0, 16'h0000);
  endtask

  // Monitor: match each new channel request and each rising fetcher ready against the scoreboard.
  always @(negedge clk) begin
    logic [1:0]  mv [2];
    logic [7:0]  ma [2][2];
    logic [3:0]  cr [2];
    logic [15:0] cd [2][4];
    exp_t        e;
    mv[0]    = {1'b0, bus_a.mem_read_valid};
    mv[1]    = bus_b.mem_read_valid;
    ma[0][0] = bus_a.mem_read_address[0];
    ma[0][1] = 8'h00;
    ma[1][0] = bus_b.mem_read_address[0];
    ma[1][1] = bus_b.mem_read_address[1];
    cr[0]    = bus_a.consumer_read_ready;
    cr[1]    = bus_b.consumer_read_ready;
    for (int k = 0; k < NC; k++) begin
      cd[0][k] = bus_a.consumer_read_data[k];
      cd[1][k] = bus_b.consumer_read_data[k];
    end
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 2; c++) begin
        if (mv[w][c] === 1'b1 && prev_mv[w][c] !== 1'b1) begin
          if (exp_grant.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_unexpected: dut %0d channel %0d addr 0x%0h, none expected",
                     w, c, ma[w][c]);
          end else begin
            e = exp_grant.pop_front();
            check_output("grant_id", 32'(w * 16 + c), 32'(e.which * 16 + e.idx));
            check_output("grant_addr", {24'h0, ma[w][c]}, {16'h0, e.val});
          end
        end
      end
      for (int k = 0; k < NC; k++) begin
        if (cr[w][k] === 1'b1 && prev_cr[w][k] !== 1'b1) begin
          if (exp_resp.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL resp_unexpected: dut %0d consumer %0d data 0x%0h, none expected",
                     w, k, cd[w][k]);
          end else begin
            e = exp_resp.pop_front();
            check_output("resp_id", 32'(w * 16 + k), 32'(e.which * 16 + e.idx));
            check_output("resp_data", {16'h0, cd[w][k]}, {16'h0, e.val});
          end
        end
      end
      prev_mv[w] = mv[w];
      prev_cr[w] = cr[w];
    end
  end

  // Directed test sequence.
  initial begin
    do_reset();
    check_output("rst_a_mem_valid", {31'h0, bus_a.mem_read_valid}, 32'h0);
    check_output("rst_a_ready", {28'h0, bus_a.consumer_read_ready}, 32'h0);
    check_output("rst_a_data2", {16'h0, bus_a.consumer_read_data[2]}, 32'h0);
    check_output("rst_b_mem_valid", {30'h0, bus_b.mem_read_valid}, 32'h0);
    check_output("rst_b_addr1", {24'h0, bus_b.mem_read_address[1]}, 32'h0);

    // Single request from consumer 2, memory answers three cycles later.
    $display("[TB] single request");
    apply_stimulus(0, 2, 1'b1);
    expect_grant(0, 0, 2);
    tick();
    check_output("t1_mem_valid", {31'h0, bus_a.mem_read_valid}, 32'h1);
    check_output("t1_mem_addr", {24'h0, bus_a.mem_read_address[0]}, 32'h1A);
    tick();
    tick();
    check_output("t1_ready_early", {31'h0, bus_a.consumer_read_ready[2]}, 32'h0);
    serve(0, 0, 2, 16'hBEEF);
    check_output("t1_ready", {31'h0, bus_a.consumer_read_ready[2]}, 32'h1);
    check_output("t1_data", {16'h0, bus_a.consumer_read_data[2]}, 32'hBEEF);
    check_output("t1_mem_valid_off", {31'h0, bus_a.mem_read_valid}, 32'h0);
    tick();
    check_output("t1_ready_held", {31'h0, bus_a.consumer_read_ready[2]}, 32'h1);
    apply_stimulus(0, 2, 1'b0);
    apply_stimulus(0, 0, 1'b1);
    expect_grant(0, 0, 0);
    tick();
    check_output("t1_ready_drop", {31'h0, bus_a.consumer_read_ready[2]}, 32'h0);
    check_output("t1_no_early_grant", {31'h0, bus_a.mem_read_valid}, 32'h0);
    check_output("t1_data_hold", {16'h0, bus_a.consumer_read_data[2]}, 32'hBEEF);
    tick();
    check_output("t1_regrant", {31'h0, bus_a.mem_read_valid}, 32'h1);
    check_output("t1_regrant_addr", {24'h0, bus_a.mem_read_address[0]}, 32'h10);
    serve(0, 0, 0, 16'h0A0A);
    apply_stimulus(0, 0, 1'b0);
    tick();

    // All four consumers at once on one channel: served 0,1,2,3 then pointer wraps.
    $display("[TB] four-way round robin");
    do_reset();
    for (int k = 0; k < NC; k++) begin
      apply_stimulus(0, k, 1'b1);
      expect_grant(0, 0, k);
    end
    for (int k = 0; k < NC; k++) begin
      tick();
      check_output("rr_grant_valid", {31'h0, bus_a.mem_read_valid}, 32'h1);
      check_output("rr_grant_addr", {24'h0, bus_a.mem_read_address[0]},
                   {24'h0, cons_addr[k]});
      serve(0, 0, k, 16'(4096 + k));
      check_output("rr_ready", {31'h0, bus_a.consumer_read_ready[k]}, 32'h1);
      apply_stimulus(0, k, 1'b0);
      tick();
      check_output("rr_idle_gap", {31'h0, bus_a.mem_read_valid}, 32'h0);
    end
    check_output("rr_ptr_wrap", {30'h0, dut_a.rr_ptr}, 32'h0);
    apply_stimulus(0, 3, 1'b1);
    apply_stimulus(0, 1, 1'b1);
    expect_grant(0, 0, 1);
    tick();
    check_output("rr_after_wrap", {24'h0, bus_a.mem_read_address[0]}, {24'h0, cons_addr[1]});
    serve(0, 0, 1, 16'h1111);
    apply_stimulus(0, 1, 1'b0);
    tick();
    expect_grant(0, 0, 3);
    tick();
    check_output("rr_next_3", {24'h0, bus_a.mem_read_address[0]}, {24'h0, cons_addr[3]});
    serve(0, 0, 3, 16'h3333);
    apply_stimulus(0, 3, 1'b0);
    tick();

    // Fairness: consumer 0 re-requests at once but waiting consumer 1 goes first.
    $display("[TB] fairness");
    do_reset();
    apply_stimulus(0, 0, 1'b1);
    apply_stimulus(0, 1, 1'b1);
    expect_grant(0, 0, 0);
    tick();
    check_output("fair_first", {24'h0, bus_a.mem_read_address[0]}, {24'h0, cons_addr[0]});
    serve(0, 0, 0, 16'h5A5A);
    apply_stimulus(0, 0, 1'b0);
    tick();
    apply_stimulus(0, 0, 1'b1);
    expect_grant(0, 0, 1);
    tick();
    check_output("fair_second", {24'h0, bus_a.mem_read_address[0]}, {24'h0, cons_addr[1]});
    serve(0, 0, 1, 16'hA5A5);
    apply_stimulus(0, 1, 1'b0);
    expect_grant(0, 0, 0);
    tick();
    tick();
    check_output("fair_third", {24'h0, bus_a.mem_read_address[0]}, {24'h0, cons_addr[0]});
    serve(0, 0, 0, 16'h0F0F);
    apply_stimulus(0, 0, 1'b0);
    tick();

    // Reset while a read is in flight, followed by a stray memory strobe.
    $display("[TB] reset during waiting");
    apply_stimulus(0, 2, 1'b1);
    expect_grant(0, 0, 2);
    tick();
    check_output("rw_granted", {31'h0, bus_a.mem_read_valid}, 32'h1);
    tick();
    reset = 1'b1;
    tick();
    check_output("rw_mem_valid", {31'h0, bus_a.mem_read_valid}, 32'h0);
    check_output("rw_mem_addr", {24'h0, bus_a.mem_read_address[0]}, 32'h0);
    check_output("rw_ready", {28'h0, bus_a.consumer_read_ready}, 32'h0);
    check_output("rw_data0", {16'h0, bus_a.consumer_read_data[0]}, 32'h0);
    check_output("rw_ptr", {30'h0, dut_a.rr_ptr}, 32'h0);
    reset = 1'b0;
    apply_stimulus(0, 2, 1'b0);
    mem_drive(0, 0, 1'b1, 16'hDEAD);
    tick();
    mem_drive(0, 0, 1'b0, 16'h0000);
    tick();
    check_output("rw_stray_ready", {28'h0, bus_a.consumer_read_ready}, 32'h0);
    check_output("rw_stray_mem_valid", {31'h0, bus_a.mem_read_valid}, 32'h0);

    // Fetcher gives up while the read is outstanding: read completes, ready pulses once.
    $display("[TB] valid drop during waiting");
    apply_stimulus(0, 3, 1'b1);
    expect_grant(0, 0, 3);
    tick();
    apply_stimulus(0, 3, 1'b0);
    tick();
    check_output("vd_read_continues", {31'h0, bus_a.mem_read_valid}, 32'h1);
    serve(0, 0, 3, 16'h7777);
    check_output("vd_pulse_high", {31'h0, bus_a.consumer_read_ready[3]}, 32'h1);
    tick();
    check_output("vd_pulse_low", {31'h0, bus_a.consumer_read_ready[3]}, 32'h0);
    apply_stimulus(0, 1, 1'b1);
    expect_grant(0, 0, 1);
    tick();
    check_output("vd_channel_free", {31'h0, bus_a.mem_read_valid}, 32'h1);
    check_output("vd_channel_addr", {24'h0, bus_a.mem_read_address[0]}, {24'h0, cons_addr[1]});
    serve(0, 0, 1, 16'h4242);
    apply_stimulus(0, 1, 1'b0);
    tick();

    // Two channels: consumers 1 and 3 granted in the same cycle, no double grant.
    $display("[TB] two channels");
    do_reset();
    apply_stimulus(1, 1, 1'b1);
    apply_stimulus(1, 3, 1'b1);
    expect_grant(1, 0, 1);
    expect_grant(1, 1, 3);
    tick();
    check_output("dc_valid", {30'h0, bus_b.mem_read_valid}, 32'h3);
    check_output("dc_addr0", {24'h0, bus_b.mem_read_address[0]}, {24'h0, cons_addr[1]});
    check_output("dc_addr1", {24'h0, bus_b.mem_read_address[1]}, {24'h0, cons_addr[3]});
    expect_resp(1, 1, 16'h1111);
    expect_resp(1, 3, 16'h3333);
    mem_drive(1, 0, 1'b1, 16'h1111);
    mem_drive(1, 1, 1'b1, 16'h3333);
    tick();
    mem_drive(1, 0, 1'b0, 16'h0000);
    mem_drive(1, 1, 1'b0, 16'h0000);
    check_output("dc_ready", {28'h0, bus_b.consumer_read_ready}, 32'hA);
    check_output("dc_data3", {16'h0, bus_b.consumer_read_data[3]}, 32'h3333);
    apply_stimulus(1, 1, 1'b0);
    apply_stimulus(1, 3, 1'b0);
    tick();
    check_output("dc_ready_off", {28'h0, bus_b.consumer_read_ready}, 32'h0);
    check_output("dc_ptr", {30'h0, dut_b.rr_ptr}, 32'h0);

    // Three requests on two channels: the third waits for the first channel to free up.
    apply_stimulus(1, 0, 1'b1);
    apply_stimulus(1, 1, 1'b1);
    apply_stimulus(1, 2, 1'b1);
    expect_grant(1, 0, 0);
    expect_grant(1, 1, 1);
    tick();
    check_output("dc3_valid", {30'h0, bus_b.mem_read_valid}, 32'h3);
    check_output("dc3_ptr", {30'h0, dut_b.rr_ptr}, 32'h2);
    serve(1, 1, 1, 16'h2222);
    apply_stimulus(1, 1, 1'b0);
    expect_grant(1, 1, 2);
    tick();
    tick();
    check_output("dc3_ch1_regrant", {24'h0, bus_b.mem_read_address[1]}, {24'h0, cons_addr[2]});
    check_output("dc3_ch0_still", {24'h0, bus_b.mem_read_address[0]}, {24'h0, cons_addr[0]});
    expect_resp(1, 0, 16'hC0C0);
    expect_resp(1, 2, 16'hC2C2);
    mem_drive(1, 0, 1'b1, 16'hC0C0);
    mem_drive(1, 1, 1'b1, 16'hC2C2);
    tick();
    mem_drive(1, 0, 1'b0, 16'h0000);
    mem_drive(1, 1, 1'b0, 16'h0000);
    apply_stimulus(1, 0, 1'b0);
    apply_stimulus(1, 2, 1'b0);
    tick();
    tick();

    @(negedge clk);
    #1;
    check_output("grants_left", 32'(exp_grant.size()), 32'h0);
    check_output("resps_left", 32'(exp_resp.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
